// File: rtl/sdu_pkg.sv
// -----------------------------------------------------------------------------
// sdu_pkg -- shared definitions for the window/FFT framing path.
//
// Contents:
//   DATA_W     default windowed sample width
//   FRAME_LEN  default samples per frame (power of two, >= 4)
//   ADDR_W     address width of one frame bank
//   rd_state_e read-side FSM states of window_frame_buffer
// -----------------------------------------------------------------------------
package sdu_pkg;

  localparam int DATA_W    = 48;
  localparam int FRAME_LEN = 128;
  localparam int ADDR_W    = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no bank being read
    READ  = 2'd1,  // issuing addresses of the current bank
    DRAIN = 2'd2   // last address issued, waiting for out_last to transfer
  } rd_state_e;

endpackage : sdu_pkg

// File: rtl/frame_bank_ram.sv
// -----------------------------------------------------------------------------
// frame_bank_ram -- simple dual-port storage for the two ping-pong frame banks.
//
// One write port, one read port with a one-cycle registered read. The read
// register only updates when rd_en is high, so it doubles as the output holding
// register of the frame buffer during backpressure.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset (clears the read register only)
//   wr_en    write strobe
//   wr_addr  write address {bank, offset}
//   wr_data  write data
//   rd_en    read strobe; rd_data loads mem[rd_addr] on the next edge
//   rd_addr  read address {bank, offset}
//   rd_data  registered read data
// -----------------------------------------------------------------------------
module frame_bank_ram #(
  parameter int DATA_W = sdu_pkg::DATA_W,
  parameter int DEPTH  = 2 * sdu_pkg::FRAME_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; bank validity is tracked by the
  // full flags in the parent, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : frame_bank_ram

// File: rtl/window_frame_buffer.sv
// -----------------------------------------------------------------------------
// window_frame_buffer -- ping-pong frame buffer between the Hamming window and
// the FFT.
//
// Input samples (no backpressure) are counted into frames of FRAME_LEN. Each
// frame is written into whichever of two banks is next in line if it is empty;
// otherwise the whole frame is dropped and overflow pulses on its first sample.
// The read side drains full banks in fill order with a valid/ready handshake,
// one sample per cycle, bubble-free across back-to-back banks.
//
// Optional feature: define FRAME_BITREV_EN to read each bank in bit-reversed
// address order (out_sop/out_last still mark output positions 0/FRAME_LEN-1).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_data    windowed sample
//   in_valid   sample qualifier
//   out_data   frame sample toward the FFT
//   out_valid  out_data qualifier
//   out_ready  FFT accept
//   out_sop    first sample of a frame
//   out_last   sample FRAME_LEN-1 of a frame
//   overflow   one-cycle pulse when an input frame is dropped
// -----------------------------------------------------------------------------
module window_frame_buffer #(
  parameter int DATA_W    = sdu_pkg::DATA_W,
  parameter int FRAME_LEN = sdu_pkg::FRAME_LEN   // power of two, >= 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_last,
  output logic              overflow
);

  import sdu_pkg::*;

  localparam int            AW       = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  // ---------------------------------------------------------------------------
  // Shared bank status
  // ---------------------------------------------------------------------------
  logic [1:0] bank_full;     // bank holds a complete frame not yet fully sent
  logic [1:0] bank_set;      // bank completes on this edge
  logic [1:0] bank_clr;      // bank's out_last transfers on this edge

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic [AW-1:0] wr_cnt;     // position of the next input sample in its frame
  logic          wr_bank;    // bank receiving the current frame
  logic          wr_sel;     // bank the next frame goes to (alternates)
  logic          wr_drop;    // current frame is being discarded

  logic          frame_start;
  logic          start_ok;
  logic          drop_now;
  logic          wr_en;
  logic          cur_bank;

  // Read-side signals referenced by the write side.
  rd_state_e     state, state_nxt;
  logic          rd_bank;
  logic          xfer_last;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bank_clr = 2'b00;
    if (xfer_last) begin
      bank_clr[rd_bank] = 1'b1;
    end

    frame_start = in_valid && (wr_cnt == '0);
    // A bank whose out_last transfers this very cycle counts as empty, which
    // keeps continuous streaming free of spurious drops.
    start_ok    = !bank_full[wr_sel] || bank_clr[wr_sel];
    drop_now    = frame_start ? !start_ok : wr_drop;
    wr_en       = in_valid && !drop_now;
    cur_bank    = frame_start ? wr_sel : wr_bank;

    bank_set = 2'b00;
    if (wr_en && (wr_cnt == LAST_IDX)) begin
      bank_set[cur_bank] = 1'b1;
    end
  end

  assign overflow = reset && frame_start && !start_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      wr_sel    <= 1'b0;
      wr_drop   <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      // The counter advances on every in_valid, dropped or not, so frame
      // alignment survives an overflow.
      if (in_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (frame_start) begin
          wr_drop <= !start_ok;
          if (start_ok) begin
            wr_bank <= wr_sel;
            wr_sel  <= ~wr_sel;
          end
        end
      end
      bank_full <= (bank_full & ~bank_clr) | bank_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  // Banks fill alternately starting at bank 0 and are read alternately starting
  // at bank 0, so toggling rd_bank after each drained frame keeps fill order.
  logic [AW-1:0] rd_idx;       // output position of the next address to issue
  logic          out_valid_q;
  logic          out_sop_q;
  logic          out_last_q;

  logic          advance;      // output register may take a new sample
  logic          issue;        // read a sample this cycle
  logic          issue_bank;
  logic [AW-1:0] issue_idx;
  logic [AW-1:0] rd_ofs;

  assign advance   = !out_valid_q || out_ready;
  assign xfer_last = out_valid_q && out_ready && out_last_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bank_full[rd_bank] && advance)   state_nxt = READ;
      READ:  if (advance && (rd_idx == LAST_IDX)) state_nxt = DRAIN;
      DRAIN: if (xfer_last)                       state_nxt = bank_full[~rd_bank] ? READ : IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  // Output (address issue) logic. IDLE and DRAIN issue position 0 in the same
  // cycle they leave, which removes the bubble between back-to-back banks.
  always_comb begin
    issue      = 1'b0;
    issue_bank = rd_bank;
    issue_idx  = rd_idx;
    unique case (state)
      IDLE: begin
        issue     = bank_full[rd_bank] && advance;
        issue_idx = '0;
      end
      READ: begin
        issue = advance;
      end
      DRAIN: begin
        if (xfer_last && bank_full[~rd_bank]) begin
          issue      = 1'b1;
          issue_bank = ~rd_bank;
          issue_idx  = '0;
        end
      end
      default: issue = 1'b0;
    endcase
  end

`ifdef FRAME_BITREV_EN
  always_comb begin
    rd_ofs = '0;
    for (int i = 0; i < AW; i++) begin
      rd_ofs[i] = issue_idx[AW-1-i];
    end
  end
`else
  assign rd_ofs = issue_idx;
`endif

  // Read datapath registers. The flags are only reloaded when the RAM read
  // register is, so data, sop and last stay aligned and hold during stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_idx      <= '0;
      rd_bank     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (issue) begin
        rd_idx <= issue_idx + 1'b1;
      end
      if ((state == DRAIN) && xfer_last) begin
        rd_bank <= ~rd_bank;
      end
      if (advance) begin
        out_valid_q <= issue;
        out_sop_q   <= issue && (issue_idx == '0);
        out_last_q  <= issue && (issue_idx == LAST_IDX);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_last  = out_last_q;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  frame_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (2 * FRAME_LEN)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr ({cur_bank, wr_cnt}),
    .wr_data (in_data),
    .rd_en   (issue),
    .rd_addr ({issue_bank, rd_ofs}),
    .rd_data (out_data)
  );

endmodule : window_frame_buffer

// File: tb/tb_window_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_window_frame_buffer -- directed bench for window_frame_buffer
// (DATA_W=48, FRAME_LEN=128). Define FRAME_BITREV_EN for the bit-reversed build.
// -----------------------------------------------------------------------------
module tb_window_frame_buffer;

  localparam int DW = 48;
  localparam int N  = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sop;
  logic          out_last;
  logic          overflow;

  window_frame_buffer #(.DATA_W(DW), .FRAME_LEN(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            first_xfer = -1;
  int            last_xfer = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_sop = 1'b0;
  logic          prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sample_at(input int k);
    int r;
    r = k;
`ifdef FRAME_BITREV_EN
    r = 0;
    for (int b = 0; b < 7; b++) begin
      if (k & (1 << b)) r |= (1 << (6 - b));
    end
`endif
    return r;
  endfunction

  // Expected output of one stored frame whose input was base+i.
  task automatic push_frame(input int base);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.data = DW'(base + sample_at(k));
      e.sop  = (k == 0);
      e.last = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // Ready modes: 0 low, 1 high, 2 pattern 1,0,0,1 by cycle number.
  function automatic logic rdy_of(input int mode);
    if (mode == 2) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    return (mode == 1);
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input int mode, input logic exp_ovf);
    exp_t e;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy_of(mode);
    @(negedge clk);
    check("overflow", overflow, exp_ovf);
    if (prev_stall) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, prev_data);
      check("hold_sop", out_sop, prev_sop);
      check("hold_last", out_last, prev_last);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_out_valid", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_sop", out_sop, e.sop);
        check("out_last", out_last, e.last);
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_sop   = out_sop;
    prev_last  = out_last;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_frame(input int base, input int mode, input logic ovf_first, input int count);
    for (int i = 0; i < count; i++) begin
      cycle(1'b1, DW'(base + i), mode, ovf_first && (i == 0));
    end
  endtask

  task automatic drain(input string tag, input int mode, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle(1'b0, '0, mode, 1'b0);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1, 1'b0);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sop", out_sop, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    prev_stall = 1'b0;
  endtask

  initial begin
    int last_in;

    // Reset state.
    #1;
    do_reset();
    idle(3);

    // Single frame, out_ready high; output latency bounded.
    push_frame(0);
    first_xfer = -1;
    send_frame(0, 1, 1'b0, N);
    last_in = cyc - 1;
    drain("single_drain", 1, 400);
    check("single_latency", (first_xfer >= 0) && (first_xfer <= last_in + 2), 1'b1);
    idle(5);

    // Backpressure with ready pattern 1,0,0,1.
    push_frame(0);
    send_frame(0, 2, 1'b0, N);
    drain("bp_drain", 2, 800);
    idle(5);

    // Overflow: three frames with the sink stalled; frame 3 is dropped.
    push_frame(32'h1000);
    push_frame(32'h2000);
    send_frame(32'h1000, 0, 1'b0, N);
    send_frame(32'h2000, 0, 1'b0, N);
    send_frame(32'h3000, 0, 1'b1, N);
    idle(4);
    drain("ovf_drain", 1, 800);
    idle(10);

    // Continuous streaming: four frames, 512 outputs with no gaps.
    first_xfer = -1;
    for (int f = 0; f < 4; f++) push_frame(f * N);
    for (int f = 0; f < 4; f++) send_frame(f * N, 1, 1'b0, N);
    drain("stream_drain", 1, 400);
    check("stream_span", last_xfer - first_xfer, 511);
    idle(5);

    // Reset mid-frame with one stored frame pending: both are discarded.
    send_frame(32'h4000, 0, 1'b0, N);
    send_frame(32'h4100, 0, 1'b0, 61);
    do_reset();
    push_frame(32'h5000);
    send_frame(32'h5000, 1, 1'b0, N);
    drain("rst_drain", 1, 400);
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_window_frame_buffer
